// File: rtl/sub32_seq.sv
// 32-bit sequential subtractor: computes a - b - bin eight bits per clock
// using two cascaded 4-bit borrow-lookahead slices. An operation takes
// four CALC cycles, and done pulses in the cycle after the last one.
//
// Handshake: start is sampled only while idle (busy=0). The edge that accepts
// start raises busy. start is ignored while busy=1, and nothing is queued.
// done is a one-cycle pulse that marks d/bout/ovf/zero as valid. Those outputs
// then hold until the next accepted start clears them.
module sub32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  output logic [31:0] d,
  output logic        bout,
  output logic        ovf,
  output logic        zero,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t      state, state_nx;
  logic [1:0]  k;
  logic [31:0] opa, opb;
  logic        br;

  logic [7:0]  sa, sb;
  logic [4:0]  lo, hi;
  logic [7:0]  diff8;
  logic        slice_bout;
  logic [31:0] d_upd;
  logic        last;

  // 4-bit borrow-lookahead slice. It returns {borrow_out, diff[3:0]}.
  // Generate is ~x&y (a borrow is created here). Propagate is ~(x^y)
  // (an incoming borrow passes through).
  function automatic logic [4:0] sub4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g, p;
    logic [4:0] c;
    g    = ~x & y;
    p    = ~(x ^ y);
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], x ^ y ^ c[3:0]};
  endfunction

  // Current 8-bit slice datapath. It computes the new slice bits and splices
  // them into the result.
  always_comb begin
    sa         = opa[{k, 3'b000} +: 8];
    sb         = opb[{k, 3'b000} +: 8];
    lo         = sub4(sa[3:0], sb[3:0], br);
    hi         = sub4(sa[7:4], sb[7:4], lo[4]);
    diff8      = {hi[3:0], lo[3:0]};
    slice_bout = hi[4];
    d_upd      = d;
    d_upd[{k, 3'b000} +: 8] = diff8;
    last       = (state == CALC) && (k == 2'd3);
  end

  // Next-state logic. In CALC, k counts slices, and the last slice returns to IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (k == 2'd3) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register. Reset has priority over start and over any CALC step.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand capture, slice counter, running borrow, and the result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      k    <= 2'd0;
      opa  <= 32'd0;
      opb  <= 32'd0;
      br   <= 1'b0;
      d    <= 32'd0;
      bout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          opa  <= a;
          opb  <= b;
          br   <= bin;
          k    <= 2'd0;
          d    <= 32'd0;
          bout <= 1'b0;
          ovf  <= 1'b0;
          zero <= 1'b0;
        end
      end else begin
        d  <= d_upd;
        br <= slice_bout;
        k  <= k + 2'd1;
        if (last) begin
          bout <= slice_bout;
          ovf  <= (opa[31] != opb[31]) && (diff8[7] != opa[31]);
          zero <= (d_upd == 32'd0);
          done <= 1'b1;
        end
      end
    end
  end

  assign busy      = (state == CALC);
  assign dbg_state = {state == CALC, k};

endmodule

// File: tb/tb_sub32_seq.sv
// Self-checking bench for sub32_seq. It applies a directed vector table,
// hand-written corner sequences (ignored start, operand changes while busy,
// reset mid-operation, start together with reset), and random operations.
// All of these are checked against an arithmetic reference model.
module tb_sub32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        bin;
  logic [31:0] d;
  logic        bout, ovf, zero, busy, done;
  logic [2:0]  dbg_state;

  int n_vec  = 0;
  int n_fail = 0;

  // Scoreboard entries are {ovf, zero, bout, d}.
  logic [34:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vt[6];

  sub32_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .d(d), .bout(bout), .ovf(ovf), .zero(zero), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model. It uses plain wide unsigned and signed arithmetic.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci);
    logic [32:0] u;
    longint      s;
    logic        v;
    u = {1'b0, x} - {1'b0, y} - {32'd0, ci};
    s = longint'($signed(x)) - longint'($signed(y)) - longint'(ci);
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {v, (u[31:0] == 32'd0), u[32], u[31:0]};
  endfunction

  // Runs one operation. The driver changes operands or pulses start while
  // busy when asked. The bench then checks the latency, the done pulse width
  // and the results against the scoreboard.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic ci,
                        input bit disturb);
    logic [34:0] e;
    @(negedge clk);
    a = x; b = y; bin = ci; start = 1'b1;
    exp_q.push_back(model(x, y, ci));
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("d_cleared", d, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      if (disturb && i < 4) begin
        a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1)); start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (i < 4) begin
        chk("done_early", {31'd0, done}, 32'd0);
        chk("busy_mid", {31'd0, busy}, 32'd1);
      end
    end
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_end", {31'd0, busy}, 32'd0);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("d", d, e[31:0]);
      chk("bout", {31'd0, bout}, {31'd0, e[32]});
      chk("zero", {31'd0, zero}, {31'd0, e[33]});
      chk("ovf", {31'd0, ovf}, {31'd0, e[34]});
    end
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("d_hold", d, e[31:0]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0; bin = 1'b0;

    // Directed vector table.
    vt[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
    vt[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vt[2] = '{32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0};
    vt[3] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vt[4] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};
    vt[5] = '{32'h12345678, 32'h12345677, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_d", d, 32'd0);
    chk("rst_flags", {28'd0, bout, ovf, zero, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Check the table constants against the model, then apply each vector to the DUT.
    for (int i = 0; i < 6; i++) begin
      logic [34:0] m;
      m = model(vt[i].a, vt[i].b, vt[i].bin);
      chk("table_model", {m[34:32], 29'd0}, {vt[i].ovf, vt[i].zero, vt[i].bout, 29'd0});
      chk("table_model_d", m[31:0], vt[i].d);
      run_op(vt[i].a, vt[i].b, vt[i].bin, 1'b0);
      chk("table_d", d, vt[i].d);
      chk("table_flags", {29'd0, ovf, zero, bout}, {29'd0, vt[i].ovf, vt[i].zero, vt[i].bout});
    end

    // Start pulses and operand changes while busy must not affect the first result.
    run_op(32'hDEADBEEF, 32'h01234567, 1'b1, 1'b1);

    // Reset sampled at edge E+2 aborts the operation with no done pulse.
    @(negedge clk);
    a = 32'hFFFF0000; b = 32'h0000FFFF; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_d", d, 32'd0);
    chk("abort_flags", {27'd0, bout, ovf, zero, busy, done}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end

    // A start asserted together with reset is ignored.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 32'h5; b = 32'h1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("start_during_rst", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("start_during_rst2", {31'd0, busy}, 32'd0);

    // After the reset, a new operation completes normally.
    run_op(32'h00000100, 32'h00000001, 1'b0, 1'b0);

    // Random operations. Half of them disturb the DUT while busy.
    for (int i = 0; i < 40; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
